instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the single-issue RISC-V core: owns the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each instruction (and its PC) to the decode stage over a valid/ready handshake. The Controller decodes the opcode field of the instruction this unit delivers. Taken branches and jumps redirect the PC. The HALT opcode (7'b1111111) stops fetching permanently until reset.

## Interface
- ADDR_W, default 9, width of the byte-addressed PC and instruction-memory address
- RESET_PC, default 0, PC loaded at reset; must be 4-byte aligned
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  ADDR_W  byte address of the requested word; stable while imem_req=1
- imem_ack  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst_ready  in  1  decode accepts inst this cycle
- inst  out  32  instruction to decode; inst[6:0] is the opcode
- inst_pc  out  ADDR_W  PC of inst
- redirect_valid  in  1  taken branch/jump; load redirect_pc
- redirect_pc  in  ADDR_W  target PC; bits [1:0] ignored and forced to 0
- halted  out  1  HALT accepted; fetch stopped

## Operation
- Handshakes: a memory transfer occurs when imem_req && imem_ack. A decode transfer ("fire") occurs when inst_valid && inst_ready.
- States: FETCH, HOLD, DISCARD, HALT. Reset enters FETCH with pc=RESET_PC.
- FETCH: imem_req=1, imem_addr=pc.
  - On ack without redirect: inst<=imem_rdata, inst_pc<=pc, go to HOLD.
  - Redirect with ack in the same cycle: drop the data, pc<=redirect_pc, stay in FETCH.
  - Redirect without ack: pc<=redirect_pc, go to DISCARD.
- DISCARD: keep imem_req=1 at the old address, which is held in a separate register, until ack. Drop the returned data, then go to FETCH at the new pc. A further redirect in DISCARD overwrites pc. An ack together with a redirect still leaves DISCARD, with pc set to the latest target.
- HOLD: inst_valid=1 and imem_req=0; inst and inst_pc are stable until fire.
  - Redirect has priority over fire: inst_valid<=0, pc<=redirect_pc, go to FETCH.
  - Fire with inst[6:0]==7'b1111111: go to HALT.
  - Any other fire: pc<=pc+4, go to FETCH.
- HALT: halted=1, imem_req=0, inst_valid=0. redirect_valid is ignored. Only reset exits this state.
- PC arithmetic: pc+4 is computed modulo 2^ADDR_W, so the maximum aligned address wraps to 0. pc[1:0] is always 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0.
  - The first imem_req=1 appears in the first cycle after reset_n is sampled high.
- Latency:
  - ack in cycle N gives inst_valid=1 in cycle N+1.
  - Fire in cycle M gives imem_req=1 with the new address in cycle M+1.
  - Peak throughput: one instruction per 2 cycles with zero-wait memory.
- Redirect in cycle R: the next request to redirect_pc is issued in cycle R+1 from FETCH or HOLD. From DISCARD it is issued in the cycle after the pending ack.
- halted rises in the cycle after the HALT instruction fires.
- Reset asserted mid-operation (any state, including a pending request) returns all outputs to reset values on the next edge. Any in-flight memory response is the memory's responsibility to cancel.
- imem_addr never changes while imem_req=1 and no ack has occurred.

## Structure
- Shared package riscv_pkg:
  - opcode constants OPC_RTYPE, OPC_ITYPE_IMM, OPC_LW, OPC_SW, OPC_BR, OPC_JAL, OPC_JALR, OPC_HALT, shared with the Controller
  - fetch_state_t enum {FETCH, HOLD, DISCARD, HALT}
- Single module with no sub-module: the PC register, the discard address register and the FSM are all small.

## Test plan
- Reset with RESET_PC=0 and zero-wait memory, inst_ready=1: imem_addr sequence 0, 4, 8; each inst_valid one cycle after its ack; inst_pc matches.
- Memory ack delayed 3 cycles at addr 8: imem_req and imem_addr=8 held for all 3 cycles; inst presented once.
- inst_ready=0 for 5 cycles in HOLD: inst and inst_pc constant, no imem_req; fire, then request at pc+4.
- redirect_valid with redirect_pc=0x40 while a request to 0x10 is pending: request to 0x10 completes and its data is dropped (no inst_valid); next request is 0x40.
- Redirect in the same cycle as ack: data dropped, next cycle requests the target. Redirect with redirect_pc=0x43: request goes to 0x40.
- Instruction word 0x0000007F fires: halted=1 next cycle, no further imem_req, redirects ignored. reset_n low: halted=0 and fetch restarts at RESET_PC. PC at 0x1FC with ADDR_W=9 wraps to 0x000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types and opcode constants shared by the fetch unit and the Controller.
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LW        = 7'b0000011;
  localparam logic [6:0] OPC_SW        = 7'b0100011;
  localparam logic [6:0] OPC_BR        = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_HALT      = 7'b1111111;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches over req/ack and hands words to decode over
// valid/ready, with branch redirect and a permanent HALT.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              started_q;
  logic [ADDR_W-1:0] target;
  logic              unused_rpc_bits;

  assign target          = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_rpc_bits = ^redirect_pc[1:0];

  // started_q keeps imem_req low in the cycle where reset is first released.
  assign imem_req   = started_q && ((state_q == FETCH) || (state_q == DISCARD));
  assign imem_addr  = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign inst_valid = (state_q == HOLD);
  assign halted     = (state_q == HALT);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = target;
          // An outstanding request must be drained at its original address.
          if (imem_req && !imem_ack) begin
            disc_addr_d = pc_q;
            state_d     = DISCARD;
          end
        end else if (imem_req && imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          state_d   = HOLD;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = target;
        if (imem_ack) state_d = FETCH;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (inst_ready) begin
          if (inst_q[6:0] == OPC_HALT) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(4);
            state_d = FETCH;
          end
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= ResetPc;
      disc_addr_q <= ResetPc;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      started_q   <= 1'b1;
    end
  end

endmodule
